// File: rtl/lockable_reg_bank_pkg.sv
// lockable_reg_bank_pkg
// Shared types and constants for the lockable register bank:
//   wr_state_e      - write-channel FSM states
//   RESP_OK/RESP_ERR - encoding of the resp_err response bit
package lockable_reg_bank_pkg;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage : lockable_reg_bank_pkg

// File: rtl/lockable_reg_bank_if.sv
// lockable_reg_bank_if
// Write request / write response channel of the lockable register bank.
//   wr_valid/wr_ready/wr_addr/wr_data  - write request (master -> slave)
//   resp_valid/resp_ready/resp_err     - registered write response (slave -> master)
// Modports: master (bus decoder side), slave (register bank side).
interface lockable_reg_bank_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_err;

  modport master (
    output wr_valid, wr_addr, wr_data, resp_ready,
    input  wr_ready, resp_valid, resp_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, resp_ready,
    output wr_ready, resp_valid, resp_err
  );
endinterface : lockable_reg_bank_if

// File: rtl/lrb_sat_counter.sv
// lrb_sat_counter
// Saturating up-counter: increments by one on each cycle inc is high and
// holds at all-ones instead of wrapping.
//   clk, rst_n - clock, async active-low reset (count -> 0)
//   inc        - increment request
//   count      - registered count value
module lrb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up on request, stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;

endmodule : lrb_sat_counter

// File: rtl/lockable_reg_bank.sv
// lockable_reg_bank
// Bank of NUM_REGS configuration registers with per-register sticky locks.
// A lock can only be cleared by rst_n. Writes arrive over a valid/ready
// request and produce a registered response flagging lock/range violations.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   bus          - lockable_reg_bank_if.slave write request/response channel
//   lock_set     - per-register lock request (sampled every cycle)
//   lock_all     - lock every register
//   lock_status  - current lock state per register
//   rd_addr      - read index; rd_data - registered read data (0 if out of range)
//   viol_cnt     - saturating count of rejected writes
//   viol_valid, viol_addr - first rejected write capture, only when the
//                  LOCKABLE_REG_BANK_VIOL_CAPTURE_EN macro is defined;
//                  otherwise tied to 0.
module lockable_reg_bank
  import lockable_reg_bank_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                NUM_REGS   = 4,
  parameter int                ADDR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0,
  parameter int                VIOL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lockable_reg_bank_if.slave    bus,
  input  logic [NUM_REGS-1:0]   lock_set,
  input  logic                  lock_all,
  output logic [NUM_REGS-1:0]   lock_status,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [VIOL_CNT_W-1:0] viol_cnt,
  output logic                  viol_valid,
  output logic [ADDR_W-1:0]     viol_addr
);

  // One extra bit so NUM_REGS itself is representable for the range check.
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NUM_REGS);

  wr_state_e           state_r;
  logic                resp_valid_r;
  logic                resp_err_r;
  logic [NUM_REGS-1:0] lock_status_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_r;

  logic [NUM_REGS-1:0] lock_eff_s;
  logic                addr_ok_s;
  logic                tgt_locked_s;
  logic                wr_hs_s;
  logic                reject_s;
  logic                commit_s;
  logic [DATA_W-1:0]   rd_mux_s;

  // Same-cycle lock requests count as locked, so a racing lock beats the write.
  always_comb begin
    lock_eff_s   = lock_status_r | lock_set | {NUM_REGS{lock_all}};
    addr_ok_s    = ({1'b0, bus.wr_addr} < NREGS_C);
    tgt_locked_s = 1'b0;
    rd_mux_s     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      tgt_locked_s = tgt_locked_s | ((bus.wr_addr == ADDR_W'(i)) & lock_eff_s[i]);
      rd_mux_s     = rd_mux_s | ({DATA_W{rd_addr == ADDR_W'(i)}} & regs_r[i]);
    end
    wr_hs_s  = (state_r == WR_IDLE) & bus.wr_valid;
    reject_s = ~addr_ok_s | tgt_locked_s;
    commit_s = wr_hs_s & ~reject_s;
  end

  // Write FSM: accept in IDLE, hold the response in RESP until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= WR_IDLE;
      resp_valid_r <= 1'b0;
      resp_err_r   <= RESP_OK;
    end else begin
      case (state_r)
        WR_IDLE: begin
          if (bus.wr_valid) begin
            state_r      <= WR_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= reject_s ? RESP_ERR : RESP_OK;
          end
        end
        WR_RESP: begin
          if (bus.resp_ready) begin
            state_r      <= WR_IDLE;
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= WR_IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= RESP_OK;
        end
      endcase
    end
  end

  // Sticky locks and register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_status_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else begin
      lock_status_r <= lock_eff_s;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_s && (bus.wr_addr == ADDR_W'(i))) begin
          regs_r[i] <= bus.wr_data;
        end
      end
    end
  end

  // Registered read port; shows pre-write contents in the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= rd_mux_s;
    end
  end

  lrb_sat_counter #(.W(VIOL_CNT_W)) u_viol_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_hs_s & reject_s),
    .count (viol_cnt)
  );

`ifdef LOCKABLE_REG_BANK_VIOL_CAPTURE_EN
  logic              viol_valid_r;
  logic [ADDR_W-1:0] viol_addr_r;

  // Capture only the first rejected address after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_valid_r <= 1'b0;
      viol_addr_r  <= '0;
    end else if (wr_hs_s && reject_s && !viol_valid_r) begin
      viol_valid_r <= 1'b1;
      viol_addr_r  <= bus.wr_addr;
    end
  end

  assign viol_valid = viol_valid_r;
  assign viol_addr  = viol_addr_r;
`else
  assign viol_valid = 1'b0;
  assign viol_addr  = '0;
`endif

  assign bus.wr_ready   = (state_r == WR_IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign lock_status    = lock_status_r;
  assign rd_data        = rd_data_r;

endmodule : lockable_reg_bank

// File: tb/tb_lockable_reg_bank.sv
// tb_lockable_reg_bank
// Self-checking bench for lockable_reg_bank with a non-power-of-two bank
// (NUM_REGS = 5). Expected write responses are pushed to a scoreboard queue
// when a write is driven and popped by a monitor when the response is consumed.
module tb_lockable_reg_bank;

  localparam int          DW   = 8;
  localparam int          NR   = 5;
  localparam int          AW   = 3;
  localparam int          CW   = 8;
  localparam logic [7:0]  RVAL = 8'h5A;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] lock_set;
  logic          lock_all;
  logic [NR-1:0] lock_status;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] viol_cnt;
  logic          viol_valid;
  logic [AW-1:0] viol_addr;

  lockable_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lockable_reg_bank #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(RVAL), .VIOL_CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lock_set(lock_set), .lock_all(lock_all), .lock_status(lock_status),
    .rd_addr(rd_addr), .rd_data(rd_data), .viol_cnt(viol_cnt),
    .viol_valid(viol_valid), .viol_addr(viol_addr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [DW-1:0] model_regs [NR];
  logic [NR-1:0] model_lock;
  int            model_cnt;
  logic          sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: compare each consumed response with the queued expectation
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got resp_err=%0b with no write pending", bus.resp_err);
      end else begin
        logic e;
        e = sb_q.pop_front();
        if (bus.resp_err !== e) begin
          n_fail++;
          $display("FAIL resp_err: got %0b expected %0b", bus.resp_err, e);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_regs[i] = RVAL;
    model_lock = '0;
    model_cnt  = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one write; returns number of cycles wr_ready stayed low afterwards.
  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [NR-1:0] ls, input logic la,
                             input int hold, output int busy);
    logic [NR-1:0] eff;
    logic          rej;
    busy = 0;
    for (int c = 0; c < 20 && !bus.wr_ready; c++) begin
      @(posedge clk); #1;
    end
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    lock_set     = ls;
    lock_all     = la;
    eff = model_lock | ls | {NR{la}};
    rej = (int'(a) >= NR) ? 1'b1 : eff[a];
    sb_q.push_back(rej);
    if (!rej) model_regs[a] = d;
    else if (model_cnt != 255) model_cnt++;
    model_lock = eff;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    lock_set     = '0;
    lock_all     = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.wr_ready) break;
      busy++;
      if (c >= hold) bus.resp_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic read_reg(input logic [AW-1:0] a, output logic [DW-1:0] d);
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (lock_status !== '0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        viol_cnt !== '0 || rd_data !== '0 || viol_valid !== 1'b0 || viol_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: lock=%b rv=%b re=%b cnt=%0d rd=%h vv=%b va=%0d expected all 0",
               lock_status, bus.resp_valid, bus.resp_err, viol_cnt, rd_data, viol_valid, viol_addr);
    end
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_reg(3'd0, d);
    n_tests++;
    if (d !== RVAL) begin
      n_fail++;
      $display("FAIL reset_val: got %h expected %h", d, RVAL);
    end
  endtask

  task automatic test_basic_write();
    int busy;
    logic [DW-1:0] d;
    drive_write(3'd2, 8'hA5, '0, 1'b0, 0, busy);
    n_tests++;
    if (busy !== 1) begin
      n_fail++;
      $display("FAIL basic_busy: wr_ready low %0d cycles expected 1", busy);
    end
    read_reg(3'd2, d);
    n_tests++;
    if (d !== model_regs[2]) begin
      n_fail++;
      $display("FAIL basic_read: got %h expected %h", d, model_regs[2]);
    end
    read_reg(3'd3, d);
    n_tests++;
    if (d !== model_regs[3]) begin
      n_fail++;
      $display("FAIL basic_read_other: got %h expected %h", d, model_regs[3]);
    end
  endtask

  task automatic test_lock();
    int busy;
    logic [DW-1:0] d;
    lock_set = 5'b00010;
    model_lock = model_lock | 5'b00010;
    @(posedge clk); #1;
    lock_set = '0;
    @(posedge clk); #1;
    drive_write(3'd1, 8'h3C, '0, 1'b0, 2, busy);
    n_tests++;
    if (busy !== 3) begin
      n_fail++;
      $display("FAIL lock_hold_busy: wr_ready low %0d cycles expected 3", busy);
    end
    read_reg(3'd1, d);
    n_tests++;
    if (d !== model_regs[1]) begin
      n_fail++;
      $display("FAIL lock_read: got %h expected %h", d, model_regs[1]);
    end
    n_tests++;
    if (viol_cnt !== CW'(model_cnt) || lock_status !== model_lock) begin
      n_fail++;
      $display("FAIL lock_state: cnt=%0d lock=%b expected cnt=%0d lock=%b",
               viol_cnt, lock_status, model_cnt, model_lock);
    end
  endtask

  task automatic test_same_cycle_lock();
    int busy;
    logic [DW-1:0] d;
    drive_write(3'd0, 8'hFF, 5'b00001, 1'b0, 1, busy);
    read_reg(3'd0, d);
    n_tests++;
    if (d !== RVAL) begin
      n_fail++;
      $display("FAIL same_cycle_read: got %h expected %h", d, RVAL);
    end
    n_tests++;
    if (lock_status !== 5'b00011 || viol_cnt !== CW'(model_cnt)) begin
      n_fail++;
      $display("FAIL same_cycle_state: lock=%b cnt=%0d expected lock=00011 cnt=%0d",
               lock_status, viol_cnt, model_cnt);
    end
  endtask

  task automatic test_out_of_range();
    int busy;
    logic [DW-1:0] d;
    drive_write(3'd6, 8'h77, '0, 1'b0, 0, busy);
    drive_write(3'd5, 8'h66, '0, 1'b0, 0, busy);
    drive_write(3'd4, 8'h99, '0, 1'b0, 0, busy);
    read_reg(3'd6, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL oor_read6: got %h expected 00", d);
    end
    read_reg(3'd4, d);
    n_tests++;
    if (d !== model_regs[4]) begin
      n_fail++;
      $display("FAIL oor_read4: got %h expected %h", d, model_regs[4]);
    end
    n_tests++;
    if (viol_cnt !== CW'(model_cnt)) begin
      n_fail++;
      $display("FAIL oor_cnt: got %0d expected %0d", viol_cnt, model_cnt);
    end
  endtask

  task automatic test_saturation();
    int busy;
    lock_all = 1'b1;
    model_lock = '1;
    @(posedge clk); #1;
    lock_all = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive_write(AW'(i % 8), 8'(i), '0, 1'b0, 0, busy);
    end
    n_tests++;
    if (viol_cnt !== 8'hFF || model_cnt != 255) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d expected 255", viol_cnt);
    end
    n_tests++;
    if (lock_status !== 5'b11111) begin
      n_fail++;
      $display("FAIL sat_lock: got %b expected 11111", lock_status);
    end
  endtask

  task automatic test_reset_mid();
    int busy;
    logic [DW-1:0] d;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd2;
    bus.wr_data  = 8'h11;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resp_pending: got %b expected 1", bus.resp_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.resp_valid !== 1'b0 || lock_status !== '0 || viol_cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rv=%b lock=%b cnt=%0d expected 0/0/0",
               bus.resp_valid, lock_status, viol_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_write(3'd2, 8'h42, '0, 1'b0, 0, busy);
    read_reg(3'd2, d);
    n_tests++;
    if (d !== 8'h42) begin
      n_fail++;
      $display("FAIL mid_after_write: got %h expected 42", d);
    end
  endtask

  task automatic test_capture();
    int busy;
    do_reset();
    drive_write(3'd3, 8'h01, 5'b01000, 1'b0, 0, busy);
    drive_write(3'd1, 8'h02, 5'b00010, 1'b0, 0, busy);
    n_tests++;
`ifdef LOCKABLE_REG_BANK_VIOL_CAPTURE_EN
    if (viol_valid !== 1'b1 || viol_addr !== 3'd3) begin
      n_fail++;
      $display("FAIL capture: vv=%b va=%0d expected 1/3", viol_valid, viol_addr);
    end
`else
    if (viol_valid !== 1'b0 || viol_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL capture_off: vv=%b va=%0d expected 0/0", viol_valid, viol_addr);
    end
`endif
    n_tests++;
    if (viol_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL capture_cnt: got %0d expected 2", viol_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.resp_ready = 1'b0;
    lock_set = '0;
    lock_all = 1'b0;
    rd_addr = '0;
    model_reset();
    test_reset();
    test_basic_write();
    test_lock();
    test_same_cycle_lock();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    test_capture();
    repeat (2) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses never seen, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lockable_reg_bank
